// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a big-endian byte stream (4-byte word count header, then payload words)
// into 32-bit words, writes them to instruction memory, and releases the core once loaded.
module imem_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        wr_en_imem_o,
  output logic [31:0] wr_addr_imem_o,
  output logic [31:0] wr_instr_imem_o,
  output logic        cpu_run_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] words_loaded_o
);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_idx;
  logic [23:0] r_shift;
  logic [15:0] r_n;
  logic [15:0] r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_instr;

  logic        w_xfer;
  logic        w_last_byte;
  logic        w_assemble;
  logic [31:0] w_word;
  logic [15:0] w_cnt_inc;
  logic        w_hdr_too_big;

  // Only the low three bytes of history are kept; the fourth comes straight from the input.
  assign w_word        = {r_shift, byte_data_i};
  assign w_xfer        = byte_valid_i & byte_ready_o;
  assign w_last_byte   = w_xfer && (r_idx == 2'd3);
  assign w_assemble    = w_xfer && ((r_state == S_HDR) || (r_state == S_DATA));
  assign w_cnt_inc     = r_cnt + 16'd1;
  assign w_hdr_too_big = w_word > 32'(MAX_WORDS);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HDR: begin
        if (w_last_byte) begin
          if (w_hdr_too_big) begin
            w_state_next = S_ERR;
          end else if (w_word == 32'd0) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_DATA;
          end
        end else begin
          w_state_next = S_HDR;
        end
      end
      S_DATA: begin
        if (w_last_byte) begin
          w_state_next = S_WRITE;
        end else begin
          w_state_next = S_DATA;
        end
      end
      S_WRITE: begin
        if (w_cnt_inc == r_n) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_DATA;
        end
      end
      S_DONE:  w_state_next = S_DONE;
      S_ERR:   w_state_next = S_ERR;
      default: w_state_next = S_HDR;
    endcase
  end

  // Byte assembly, header capture, write-port registers and word counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
      r_n     <= 16'd0;
      r_cnt   <= 16'd0;
      r_addr  <= 32'd0;
      r_instr <= 32'd0;
    end else begin
      if (w_assemble) begin
        r_shift <= w_word[23:0];
        r_idx   <= r_idx + 2'd1;
      end
      if ((r_state == S_HDR) && w_last_byte) begin
        r_n <= w_word[15:0];
      end
      if ((r_state == S_DATA) && w_last_byte) begin
        r_instr <= w_word;
        r_addr  <= BASE_ADDR + {14'd0, r_cnt, 2'b00};
      end
      if (r_state == S_WRITE) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign byte_ready_o    = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_ERR);
  assign wr_en_imem_o    = (r_state == S_WRITE);
  assign wr_addr_imem_o  = r_addr;
  assign wr_instr_imem_o = r_instr;
  assign cpu_run_o       = (r_state == S_DONE);
  assign done_o          = (r_state == S_DONE);
  assign error_o         = (r_state == S_ERR);
  assign words_loaded_o  = r_cnt;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the single-cycle MIPS core; sole writer of the instruction memory's write port.
- Receives a big-endian byte stream (valid/ready) and assembles it into 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses.
- Holds the core in reset until the whole program image is loaded, then releases it.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; word-aligned.
- MAX_WORDS, 1024: largest accepted program length in words (1..65535).

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- byte_valid_i  input  1  byte_data_i is valid this cycle.
- byte_data_i  input  8  stream byte.
- byte_ready_o  output  1  loader accepts a byte this cycle; a transfer occurs when valid & ready.
- wr_en_imem_o  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr_imem_o  output  32  byte address for the write.
- wr_instr_imem_o  output  32  instruction word to write.
- cpu_run_o  output  1  1 = core released; top drives the core reset from this signal.
- done_o  output  1  load completed successfully.
- error_o  output  1  header length exceeded MAX_WORDS.
- words_loaded_o  output  16  number of words written so far.

Behaviour:
- Stream format: 4-byte header (word count N, MSB first), then N×4 payload bytes, each word MSB first.
- States: HDR, DATA, WRITE, DONE, ERR.
- Reset (reset=0 at an edge):
  - state=HDR; byte index=0; N=0; word counter=0; assembly register=0.
  - All outputs 0 except byte_ready_o, which is 1 (driven by state HDR).
- Reset has priority over every other event, including mid-word and mid-WRITE; a partially assembled word is discarded.
- Byte assembly: on each accepted byte, shift_reg <= {shift_reg[23:0], byte_data_i}; the 2-bit byte index increments and wraps 3->0.
- HDR state:
  - byte_ready_o=1.
  - On the 4th accepted byte, N = assembled value; the lower 16 bits are used after the range check, and the check uses the full 32 bits.
  - N > MAX_WORDS -> ERR.
  - N == 0 -> DONE.
  - Otherwise -> DATA.
- DATA state:
  - byte_ready_o=1.
  - On the 4th accepted byte of a word -> WRITE; the full word is latched into wr_instr_imem_o's register.
- WRITE state (exactly one cycle):
  - byte_ready_o=0; wr_en_imem_o=1.
  - wr_addr_imem_o = BASE_ADDR + (word counter << 2), computed mod 2^32.
  - wr_instr_imem_o = assembled word.
  - At the edge ending WRITE: word counter increments; if the new count == N -> DONE, else -> DATA.
- wr_addr_imem_o and wr_instr_imem_o hold their last values outside WRITE; wr_en_imem_o is 0 outside WRITE.
- Latency: the write strobe is asserted in the cycle immediately after the edge that accepts the 4th byte of a word.
- DONE state:
  - cpu_run_o=1, done_o=1, byte_ready_o=0.
  - Sticky until reset; extra stream bytes are not accepted.
- ERR state:
  - error_o=1, cpu_run_o=0.
  - byte_ready_o=1 so the source drains; accepted bytes are discarded and no writes occur.
  - Sticky until reset.
- Flow control: byte_valid_i with byte_ready_o=0 is not a transfer; the source must hold the byte. Idle gaps (valid=0) in any state are allowed and change nothing.
- words_loaded_o = word counter. It equals N in DONE and 0 in ERR.
- cpu_run_o, done_o and error_o are decoded from the state register only; they are never combinational from inputs.

Test Plan:
- Reset, then stream 00 00 00 02, 20 08 00 05, 21 09 FF FF:
  - two write pulses: addr 0x0 data 0x20080005, then addr 0x4 data 0x2109FFFF;
  - cpu_run_o=1 and done_o=1 in the cycle after the 2nd write; words_loaded_o=2.
- Header 00 00 00 00 -> DONE the cycle after the 4th header byte; no wr_en_imem_o pulse; cpu_run_o=1.
- With MAX_WORDS=4, header 00 00 00 05 followed by 8 bytes:
  - error_o=1; byte_ready_o stays 1; no writes; cpu_run_o=0.
- Header N=1 with valid toggled 1,0,0,1,0,1,1 and back-to-back bytes arriving during WRITE:
  - ready=0 during WRITE; the bytes are held, not lost;
  - the written word equals the transmitted bytes in order.
- Reset asserted after 2 of 4 payload bytes, then a fresh header N=1 and word DE AD BE EF:
  - single write at BASE_ADDR with data 0xDEADBEEF; the earlier partial bytes have no effect.
- After DONE, hold byte_valid_i=1 for 10 cycles -> byte_ready_o=0 throughout, no writes, and done_o remains 1.
